// File: rtl/osd_stm_mor1kx_buf_pkg.sv
// Shared types and constants for the buffered mor1kx-to-STM trace adapter.
package osd_stm_mor1kx_buf_pkg;

  localparam int unsigned StmIdW = 16;
  localparam logic [StmIdW-1:0] STM_OVF_ID = 16'h0000;

  typedef struct packed {
    logic [StmIdW-1:0] id;
    logic [31:0]       value;
  } stm_event_t;

  typedef enum logic [0:0] {
    StNormal,
    StOvf
  } ovf_state_e;

endpackage

// File: rtl/osd_stm_mor1kx_buf_if.sv
// Valid/ready event stream from the adapter towards the STM core.
interface osd_stm_mor1kx_buf_if #(
  parameter int unsigned XLEN = 32
);
  logic            valid;
  logic            ready;
  logic [15:0]     id;
  logic [XLEN-1:0] value;

  modport master (output valid, output id, output value, input ready);
  modport slave  (input valid, input id, input value, output ready);
endinterface

// File: rtl/osd_fifo_fwft.sv
// First-word-fall-through FIFO; head is visible combinationally, zero when empty.
module osd_fifo_fwft #(
  parameter int unsigned WIDTH = 48,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [PW:0]      level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]      level_q, level_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push_i);
    rd_ptr_d = rd_ptr_q + PW'(pop_i);
    level_d  = level_q;
    unique case ({push_i, pop_i})
      2'b10:   level_d = level_q + (PW+1)'(1);
      2'b01:   level_d = level_q - (PW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // When full, wr_ptr equals rd_ptr; a push+pop overwrites the slot leaving this edge.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == (PW+1)'(DEPTH));
  assign level_o = level_q;
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/osd_stm_mor1kx_buf.sv
// Detects l.nop K trace events, pairs them with a shadowed GPR and queues them
// for the STM core, replacing lost events with an in-band overflow record.
module osd_stm_mor1kx_buf
  import osd_stm_mor1kx_buf_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned VALUE_REG = 3,
  parameter logic [15:0] MARKER    = 16'h1500,
  parameter int unsigned CNT_W     = 16,
  parameter logic [15:0] OVF_ID    = STM_OVF_ID
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    tr_valid,
  input  logic [31:0]             tr_insn,
  input  logic                    tr_wben,
  input  logic [4:0]              tr_wbreg,
  input  logic [XLEN-1:0]         tr_wbdata,
  osd_stm_mor1kx_buf_if.master    out_if,
  output logic                    ovf_pending,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int unsigned EntW = StmIdW + XLEN;
  localparam logic [4:0] ValueRegIdx = 5'(VALUE_REG);

  logic [XLEN-1:0]  shadow_q, shadow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ovf_state_e       state_q, state_d;

  logic            ev, pop, room, push, full, empty;
  logic [EntW-1:0] push_data, head;
  logic [XLEN-1:0] cnt_ext;

  assign ev   = enable && tr_valid && (tr_insn[31:16] == MARKER) && (tr_insn[15:0] != 16'h0);
  assign pop  = !empty && out_if.ready;
  assign room = !full || pop;

  always_comb begin
    shadow_d = shadow_q;
    if (tr_wben && (tr_wbreg == ValueRegIdx)) shadow_d = tr_wbdata;
  end

  always_comb begin
    cnt_ext             = '0;
    cnt_ext[CNT_W-1:0]  = cnt_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StNormal;
      cnt_q    <= '0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
    end
  end

  // Once an event is lost nothing may be queued ahead of the overflow record.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StNormal: if (ev && !room) state_d = StOvf;
      StOvf:    if (room && !ev) state_d = StNormal;
      default:  state_d = StNormal;
    endcase
  end

  always_comb begin
    push      = 1'b0;
    push_data = {tr_insn[15:0], shadow_q};
    cnt_d     = cnt_q;
    unique case (state_q)
      StNormal: begin
        if (ev && room) push = 1'b1;
        else if (ev) cnt_d = CNT_W'(1);
      end
      StOvf: begin
        if (room) begin
          push      = 1'b1;
          push_data = {OVF_ID, cnt_ext};
          cnt_d     = ev ? CNT_W'(1) : '0;
        end else if (ev && (cnt_q != '1)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  osd_fifo_fwft #(
    .WIDTH (EntW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  assign out_if.valid = !empty;
  assign out_if.id    = head[EntW-1:XLEN];
  assign out_if.value = head[XLEN-1:0];
  assign ovf_pending  = (state_q == StOvf);

endmodule

// File: tb/tb_osd_stm_mor1kx_buf.sv
// Directed and randomized checks of the buffered trace adapter against a queue model.
module tb_osd_stm_mor1kx_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable, tr_valid, tr_wben;
  logic [31:0] tr_insn, tr_wbdata;
  logic [4:0]  tr_wbreg;
  logic        ovf_pending;
  logic [2:0]  level;

  int checks = 0;
  int errors = 0;

  logic [47:0] m_q[$];
  logic [47:0] got[$];
  logic [31:0] m_shadow;
  bit          m_ovf;
  int unsigned m_cnt;

  osd_stm_mor1kx_buf_if #(.XLEN(32)) out_if ();

  osd_stm_mor1kx_buf #(
    .XLEN(32), .DEPTH(4), .VALUE_REG(3), .MARKER(16'h1500), .CNT_W(16), .OVF_ID(16'h0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .tr_valid    (tr_valid),
    .tr_insn     (tr_insn),
    .tr_wben     (tr_wben),
    .tr_wbreg    (tr_wbreg),
    .tr_wbdata   (tr_wbdata),
    .out_if      (out_if),
    .ovf_pending (ovf_pending),
    .level       (level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_shadow = '0;
    m_ovf    = 0;
    m_cnt    = 0;
  endtask

  // Evaluated with the inputs that were present at the edge just taken.
  task automatic model_update();
    bit ev, pop, room;
    ev   = enable && tr_valid && tr_insn[31:16] == 16'h1500 && tr_insn[15:0] != 0;
    pop  = m_q.size() > 0 && out_if.ready;
    room = m_q.size() < 4 || pop;
    if (pop) void'(m_q.pop_front());
    if (!m_ovf) begin
      if (ev && room) m_q.push_back({tr_insn[15:0], m_shadow});
      else if (ev) begin m_ovf = 1; m_cnt = 1; end
    end else if (room) begin
      m_q.push_back({16'h0000, m_cnt[31:0]});
      if (ev) m_cnt = 1;
      else begin m_ovf = 0; m_cnt = 0; end
    end else if (ev && m_cnt < 65535) begin
      m_cnt++;
    end
    if (tr_wben && tr_wbreg == 5'd3) m_shadow = tr_wbdata;
  endtask

  task automatic compare();
    check("out_valid", 64'(out_if.valid), 64'(m_q.size() > 0));
    check("level", 64'(level), 64'(m_q.size()));
    check("ovf_pending", 64'(ovf_pending), 64'(m_ovf));
    if (m_q.size() > 0) check("head", {16'h0, out_if.id, out_if.value}, {16'h0, m_q[0]});
  endtask

  task automatic step(input bit e, input bit v, input logic [31:0] i, input bit wb,
                      input logic [4:0] r, input logic [31:0] d, input bit rd);
    enable = e; tr_valid = v; tr_insn = i; tr_wben = wb; tr_wbreg = r; tr_wbdata = d;
    out_if.ready = rd;
    #1;
    if (out_if.valid && rd) got.push_back({out_if.id, out_if.value});
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare();
  endtask

  task automatic idle(input bit rd);
    step(1, 0, 32'h0, 0, 5'd0, 32'h0, rd);
  endtask

  task automatic event_id(input logic [15:0] id, input bit rd);
    step(1, 1, {16'h1500, id}, 0, 5'd0, 32'h0, rd);
  endtask

  initial begin
    rst = 1'b0;
    enable = 0; tr_valid = 0; tr_insn = 0; tr_wben = 0; tr_wbreg = 0; tr_wbdata = 0;
    out_if.ready = 0;
    model_reset();
    @(negedge clk);
    check("rst_valid", 64'(out_if.valid), 64'd0);
    check("rst_id", 64'(out_if.id), 64'd0);
    check("rst_value", 64'(out_if.value), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_ovf", 64'(ovf_pending), 64'd0);
    rst = 1'b1;

    // Basic event, one-cycle latency, then popped.
    step(1, 0, 32'h0, 1, 5'd3, 32'hDEADBEEF, 1);
    event_id(16'h0042, 1);
    check("lat_valid", 64'(out_if.valid), 64'd1);
    check("lat_id", 64'(out_if.id), 64'h42);
    check("lat_value", 64'(out_if.value), 64'hDEADBEEF);
    idle(1);
    check("popped", 64'(out_if.valid), 64'd0);

    // Same-cycle writeback is not visible; K==0 and wrong marker ignored.
    step(1, 0, 32'h0, 1, 5'd3, 32'h5, 1);
    step(1, 1, 32'h15000007, 1, 5'd3, 32'h11111111, 1);
    check("pre_edge_shadow", 64'(out_if.value), 64'h5);
    step(1, 1, 32'h15000000, 0, 5'd0, 32'h0, 1);
    step(1, 1, 32'h15010001, 0, 5'd0, 32'h0, 1);
    check("no_event", 64'(out_if.valid), 64'd0);

    // Overflow with two drops.
    got.delete();
    for (int k = 1; k <= 6; k++) event_id(16'(k), 0);
    check("full_level", 64'(level), 64'd4);
    check("full_ovf", 64'(ovf_pending), 64'd1);
    for (int k = 0; k < 6; k++) idle(1);
    check("drain1_n", 64'(got.size()), 64'd5);
    if (got.size() == 5) begin
      for (int k = 0; k < 4; k++) check("drain1_id", 64'(got[k][47:32]), 64'(k + 1));
      check("drain1_rec", 64'(got[4]), 64'h0000_0000_0002);
    end

    // Further drops while pending, then a normal event after the record.
    got.delete();
    for (int k = 1; k <= 8; k++) event_id(16'(k), 0);
    for (int k = 0; k < 6; k++) idle(1);
    event_id(16'h0009, 1);
    idle(1);
    check("drain2_n", 64'(got.size()), 64'd6);
    if (got.size() == 6) begin
      check("drain2_rec", 64'(got[4]), 64'h0000_0000_0004);
      check("drain2_ev9", 64'(got[5][47:32]), 64'h9);
    end

    // Full FIFO with simultaneous pop and push.
    for (int k = 1; k <= 4; k++) event_id(16'(k), 0);
    event_id(16'h000A, 1);
    check("pp_level", 64'(level), 64'd4);
    check("pp_ovf", 64'(ovf_pending), 64'd0);
    for (int k = 0; k < 5; k++) idle(1);

    // Asynchronous reset while full with a pending overflow.
    for (int k = 1; k <= 5; k++) event_id(16'(k), 0);
    check("pre_rst_ovf", 64'(ovf_pending), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("arst_valid", 64'(out_if.valid), 64'd0);
    check("arst_level", 64'(level), 64'd0);
    check("arst_ovf", 64'(ovf_pending), 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    event_id(16'h0033, 1);
    check("post_rst_id", 64'(out_if.id), 64'h33);
    check("post_rst_value", 64'(out_if.value), 64'h0);
    idle(1);

    // Disabled capture.
    step(0, 1, 32'h15000055, 0, 5'd0, 32'h0, 1);
    check("disabled", 64'(out_if.valid), 64'd0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] ins;
      ins = $urandom;
      if ($urandom_range(0, 3) != 0) ins = {16'h1500, 16'($urandom_range(0, 20))};
      step($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1, ins,
           $urandom_range(0, 1) == 1, 5'($urandom_range(0, 5)), $urandom,
           $urandom_range(0, 2) != 0 && (n % 200) > 40);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
